// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: buffered serial audio transmitter with I2S or TDM framing.
//
// Samples are written into a small FIFO in channel order 0..CHANNELS-1.
// Once per frame, one clk before the falling bit_clk edge that drives the
// slot-0 MSB, a whole frame (CHANNELS samples) is moved into a shift
// register. If a full frame is not yet buffered, an all-zero frame is sent
// instead and underrun pulses for one clk.
//
// Framing: TDM=0 -> frame_clk is LRCK (0 = slot 0, 1 = slot 1).
//          TDM=1 -> frame_clk is a one-bit-period sync pulse.
// Serial data lags frame timing by one bit_clk period (I2S-style delay).
//
// Ports:
//   clk           system clock (single domain)
//   reset         asynchronous active-low reset
//   sample_data   two's-complement sample (SAMPLE_W bits)
//   sample_valid  sample_data is valid
//   sample_ready  FIFO can accept a sample
//   bit_clk       serial bit clock (BCLK_DIV clk cycles per period)
//   frame_clk     LRCK (I2S) or frame sync pulse (TDM)
//   sdata         serial data, MSB first
//   underrun      one-clk pulse for each frame sent as silence
//   fifo_level    current FIFO entry count (only with I2S_TDM_TX_LEVEL_EN)
//
// Optional feature macro: I2S_TDM_TX_LEVEL_EN adds the fifo_level output.
module i2s_tdm_tx #(
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 32,
    parameter int CHANNELS = 2,
    parameter int TDM      = 0,
    parameter int BCLK_DIV = 4,
    parameter int DEPTH    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                bit_clk,
    output logic                frame_clk,
    output logic                sdata,
    output logic                underrun
`ifdef I2S_TDM_TX_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] fifo_level
`endif
);

    localparam int FRAME_BITS = CHANNELS * SLOT_W;
    localparam int HALF       = BCLK_DIV / 2;
    localparam int DIV_W      = $clog2(BCLK_DIV);
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int LVL_W      = PTR_W + 1;

    logic [DIV_W-1:0]      div_cnt_r;
    logic                  bit_clk_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic                  frame_clk_r;
    logic                  sdata_r;
    logic                  underrun_r;
    logic [FRAME_BITS-1:0] shreg_r;

    logic [SAMPLE_W-1:0]   mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [LVL_W-1:0]      count_r;
    logic                  ready_r;

    logic                  fall_s;
    logic                  rise_s;
    logic                  pop_time_s;
    logic                  pop_ok_s;
    logic                  wr_en_s;
    logic [LVL_W-1:0]      count_next_s;
    logic [CNT_W-1:0]      bit_cnt_next_s;
    logic                  frame_next_s;
    logic [FRAME_BITS-1:0] load_s;

    // The edge that ends the high half of bit_clk is the only edge where
    // frame_clk and sdata are allowed to move.
    assign fall_s     = (div_cnt_r == DIV_W'(BCLK_DIV - 1));
    assign rise_s     = (div_cnt_r == DIV_W'(HALF - 1));
    // One clk ahead of the falling edge that leaves bit period 0.
    assign pop_time_s = (bit_cnt_r == '0) && (div_cnt_r == DIV_W'(BCLK_DIV - 2));
    assign pop_ok_s   = pop_time_s && (count_r >= LVL_W'(CHANNELS));
    assign wr_en_s    = sample_valid && ready_r;

    assign sample_ready = ready_r;
    assign bit_clk      = bit_clk_r;
    assign frame_clk    = frame_clk_r;
    assign sdata        = sdata_r;
    assign underrun     = underrun_r;

`ifdef I2S_TDM_TX_LEVEL_EN
    assign fifo_level = count_r;
`else
    // No level output in this build; count_r stays internal.
`endif

    // FIFO occupancy after this edge's write and frame pop.
    always_comb begin
        count_next_s = count_r;
        if (wr_en_s) begin
            count_next_s = count_next_s + LVL_W'(1);
        end else begin
            count_next_s = count_next_s;
        end
        if (pop_ok_s) begin
            count_next_s = count_next_s - LVL_W'(CHANNELS);
        end else begin
            count_next_s = count_next_s;
        end
    end

    // Bit counter successor and the frame_clk level for the next bit period.
    always_comb begin
        bit_cnt_next_s = bit_cnt_r + CNT_W'(1);
        if (bit_cnt_r == CNT_W'(FRAME_BITS - 1)) begin
            bit_cnt_next_s = '0;
        end else begin
            bit_cnt_next_s = bit_cnt_r + CNT_W'(1);
        end
        if (TDM != 0) begin
            frame_next_s = (bit_cnt_next_s == '0);
        end else begin
            frame_next_s = (bit_cnt_next_s >= CNT_W'(SLOT_W));
        end
    end

    // Assemble a frame: slot c holds the c-th oldest sample, left-justified.
    always_comb begin
        load_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            load_s[FRAME_BITS-1-c*SLOT_W -: SAMPLE_W] = mem_r[rd_ptr_r + PTR_W'(c)];
        end
    end

    // Bit clock divider, frame timing, shift register and serial outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_r   <= '0;
            bit_clk_r   <= 1'b0;
            bit_cnt_r   <= '0;
            frame_clk_r <= 1'b0;
            sdata_r     <= 1'b0;
            underrun_r  <= 1'b0;
            shreg_r     <= '0;
        end else begin
            div_cnt_r  <= fall_s ? '0 : div_cnt_r + DIV_W'(1);
            underrun_r <= pop_time_s && !pop_ok_s;
            if (rise_s) begin
                bit_clk_r <= 1'b1;
            end else if (fall_s) begin
                bit_clk_r <= 1'b0;
            end
            if (fall_s) begin
                bit_cnt_r   <= bit_cnt_next_s;
                frame_clk_r <= frame_next_s;
                sdata_r     <= shreg_r[FRAME_BITS-1];
            end
            // Loading and shifting never coincide: they sit on adjacent edges.
            if (pop_time_s) begin
                shreg_r <= pop_ok_s ? load_s : '0;
            end else if (fall_s) begin
                shreg_r <= shreg_r << 1;
            end
        end
    end

    // FIFO pointers, occupancy and registered ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ready_r  <= 1'b0;
        end else begin
            count_r <= count_next_s;
            ready_r <= (count_next_s != LVL_W'(DEPTH));
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(CHANNELS);
            end
        end
    end

    // Sample storage; contents are only meaningful under count_r.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= sample_data;
        end
    end

endmodule
